// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC datapath: Q2.20 fixed-point
// format and IEEE-754 single-precision field layout.
package cordic_pkg;

  localparam int FIX_W     = 22;
  localparam int FRAC_BITS = 20;

  localparam int FLT_W    = 32;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [FIX_W-1:0] FIX_MAX = 22'h1FFFFF;
  localparam logic [FIX_W-1:0] FIX_MIN = 22'h200000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

endpackage

// File: rtl/lzc22.sv
// 22-bit leading-zero counter; returns 22 for an all-zero input.
module lzc22 (
  input  logic [21:0] d,
  output logic [4:0]  lz
);

  logic found;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through the loop infers a latch.
    lz    = 5'd22;
    found = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      if (!found && d[i]) begin
        lz    = 5'(21 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_float_conv.sv
// Registered, independent float->Q2.20 and Q2.20->float converters,
// one-cycle latency each, full throughput.
module fixed_float_conv
  import cordic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FLT_W-1:0] fl_in,
  input  logic             fl_in_valid,
  output logic [FIX_W-1:0] fix_out,
  output logic             fix_out_valid,
  input  logic [FIX_W-1:0] fix_in,
  input  logic             fix_in_valid,
  output logic [FLT_W-1:0] fl_out,
  output logic             fl_out_valid
);

  localparam int SIG_W   = MANT_W + 1;
  // Smallest biased exponent whose value reaches |x| >= 2.
  localparam int SAT_EXP = EXP_BIAS + FIX_W - 1 - FRAC_BITS;
  // Right shift applied to the significand is RSH_BASE - e.
  localparam int RSH_BASE = EXP_BIAS + MANT_W - FRAC_BITS;
  localparam int EXP_MAX  = (1 << EXP_W) - 1;

  // ---------------- float -> fixed ----------------
  float_t             f;
  logic [SIG_W-1:0]   sig;
  logic [SIG_W-1:0]   f_mag;
  logic [FIX_W-1:0]   f_mag_fix;
  logic [FIX_W-1:0]   fix_d;
  int                 rsh;

  assign f         = float_t'(fl_in);
  assign sig       = {1'b1, f.mant};
  assign rsh       = RSH_BASE - int'(f.exp);
  assign f_mag_fix = f_mag[FIX_W-1:0];

  always_comb begin
    f_mag = '0;
    fix_d = '0;
    if (f.exp == '0) begin
      fix_d = '0;
    end else if (int'(f.exp) == EXP_MAX && f.mant != '0) begin
      fix_d = '0;
    end else if (int'(f.exp) >= SAT_EXP) begin
      fix_d = f.sign ? FIX_MIN : FIX_MAX;
    end else begin
      if (rsh < SIG_W) f_mag = sig >> rsh;
      fix_d = f.sign ? -f_mag_fix : f_mag_fix;
    end
  end

  // ---------------- fixed -> float ----------------
  logic             x_sign;
  logic [FIX_W-1:0] x_mag;
  logic [FIX_W-1:0] x_norm;
  logic [4:0]       x_lz;
  logic [EXP_W-1:0] x_exp;
  logic [MANT_W-1:0] x_mant;
  logic [FLT_W-1:0] fl_d;

  assign x_sign = fix_in[FIX_W-1];
  // Negating FIX_MIN wraps to itself, which read unsigned is exactly 2^21.
  assign x_mag  = x_sign ? -fix_in : fix_in;

  lzc22 u_lzc (
    .d  (x_mag),
    .lz (x_lz)
  );

  assign x_norm = x_mag << x_lz;
  assign x_exp  = EXP_W'(SAT_EXP - int'(x_lz));
  assign x_mant = {x_norm[FIX_W-2:0], (MANT_W - FIX_W + 1)'(0)};
  assign fl_d   = (x_mag == '0) ? '0 : {x_sign, x_exp, x_mant};

  // ---------------- output registers ----------------
  // NOTE: state uses non-blocking assignments; data registers are reset too, since outputs must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fix_out       <= '0;
      fix_out_valid <= 1'b0;
      fl_out        <= '0;
      fl_out_valid  <= 1'b0;
    end else begin
      fix_out_valid <= fl_in_valid;
      fl_out_valid  <= fix_in_valid;
      if (fl_in_valid)  fix_out <= fix_d;
      if (fix_in_valid) fl_out  <= fl_d;
    end
  end

endmodule

// File: tb/tb_fixed_float_conv.sv
// Directed and randomized checks for fixed_float_conv: conversions, saturation,
// hold/valid timing, round trip and asynchronous reset.
module tb_fixed_float_conv;

  logic        clk;
  logic        rst_n;
  logic [31:0] fl_in;
  logic        fl_in_valid;
  logic [21:0] fix_out;
  logic        fix_out_valid;
  logic [21:0] fix_in;
  logic        fix_in_valid;
  logic [31:0] fl_out;
  logic        fl_out_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  fixed_float_conv dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fl_in         (fl_in),
    .fl_in_valid   (fl_in_valid),
    .fix_out       (fix_out),
    .fix_out_valid (fix_out_valid),
    .fix_in        (fix_in),
    .fix_in_valid  (fix_in_valid),
    .fl_out        (fl_out),
    .fl_out_valid  (fl_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference models written straight from the format definitions.
  function automatic logic [21:0] model_fl2fix(input logic [31:0] v);
    int          e;
    longint      sig;
    longint      mag;
    logic [21:0] r;
    e   = int'(v[30:23]);
    sig = longint'({1'b1, v[22:0]});
    if (e == 0) return 22'h0;
    if (e == 255 && v[22:0] != 0) return 22'h0;
    if (e >= 128) return v[31] ? 22'h200000 : 22'h1FFFFF;
    mag = sig;
    for (int k = 0; k < 130 - e; k++) mag = mag / 2;
    r = 22'(mag);
    if (v[31]) r = 22'(0 - mag);
    return r;
  endfunction

  function automatic logic [31:0] model_fix2fl(input logic [21:0] v);
    longint mag;
    int     p;
    longint mant;
    logic   s;
    s   = v[21];
    mag = s ? (longint'(4194304) - longint'(v)) : longint'(v);
    if (mag == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 22; k++) if ((mag >> k) & 1) p = k;
    mant = (mag - (longint'(1) << p)) << (23 - p);
    return {s, 8'(127 + p - 20), 23'(mant)};
  endfunction

  task automatic do_fl(input string tag, input logic [31:0] f, input logic [21:0] exp);
    fl_in       = f;
    fl_in_valid = 1'b1;
    @(negedge clk);
    check({tag, " fix_out"}, 32'(fix_out), 32'(exp));
    check({tag, " fix_vld"}, 32'(fix_out_valid), 32'd1);
  endtask

  task automatic do_fix(input string tag, input logic [21:0] x, input logic [31:0] exp);
    fix_in       = x;
    fix_in_valid = 1'b1;
    @(negedge clk);
    check({tag, " fl_out"}, fl_out, exp);
    check({tag, " fl_vld"}, 32'(fl_out_valid), 32'd1);
  endtask

  logic [31:0] fl_vec  [12] = '{32'h3F800000, 32'h3F000000, 32'hBF490FDB, 32'h00000000,
                                32'h40200000, 32'hC0000000, 32'h7F800000, 32'h7FC00000,
                                32'hFF800000, 32'h35800000, 32'h35000000, 32'h3FFFFFFF};
  logic [21:0] fl_exp  [12] = '{22'h100000, 22'h080000, 22'h336F03, 22'h000000,
                                22'h1FFFFF, 22'h200000, 22'h1FFFFF, 22'h000000,
                                22'h200000, 22'h000001, 22'h000000, 22'h1FFFFF};
  logic [21:0] fix_vec [7]  = '{22'h09B74E, 22'h100000, 22'h200000, 22'h000001,
                                22'h000000, 22'h1FFFFF, 22'h3FFFFF};
  logic [31:0] fix_exp [7]  = '{32'h3F1B74E0, 32'h3F800000, 32'hC0000000, 32'h35800000,
                                32'h00000000, 32'h3FFFFFF8, 32'hB5800000};

  initial begin
    logic [31:0] rf, prev_f;
    logic [21:0] rx, prev_x, code;
    logic [31:0] mid;

    rst_n        = 1'b0;
    fl_in        = '0;
    fl_in_valid  = 1'b0;
    fix_in       = '0;
    fix_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst fix_out", 32'(fix_out), 32'h0);
    check("rst fix_vld", 32'(fix_out_valid), 32'h0);
    check("rst fl_out", fl_out, 32'h0);
    check("rst fl_vld", 32'(fl_out_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) do_fl($sformatf("fl[%0d]", i), fl_vec[i], fl_exp[i]);
    fl_in_valid = 1'b0;
    fl_in       = 32'h3F800000;
    @(negedge clk);
    check("fl hold val", 32'(fix_out), 32'(fl_exp[11]));
    check("fl drop vld", 32'(fix_out_valid), 32'd0);

    for (int i = 0; i < 7; i++) do_fix($sformatf("fix[%0d]", i), fix_vec[i], fix_exp[i]);
    fix_in_valid = 1'b0;
    fix_in       = 22'h100000;
    @(negedge clk);
    check("fix hold val", fl_out, fix_exp[6]);
    check("fix drop vld", 32'(fl_out_valid), 32'd0);

    // Both paths every cycle with random operands.
    for (int i = 0; i <= 300; i++) begin
      if (i > 0) begin
        check("rnd fix_out", 32'(fix_out), 32'(model_fl2fix(prev_f)));
        check("rnd fl_out", fl_out, model_fix2fl(prev_x));
        check("rnd vlds", {30'd0, fix_out_valid, fl_out_valid}, 32'd3);
      end
      rf = $urandom;
      if (i % 8 != 0) rf[30:23] = 8'($urandom_range(100, 130));
      rx = 22'($urandom);
      fl_in        = rf;
      fix_in       = rx;
      fl_in_valid  = 1'b1;
      fix_in_valid = 1'b1;
      prev_f = rf;
      prev_x = rx;
      @(negedge clk);
    end

    // Async reset between edges while both paths are busy.
    #2 rst_n = 1'b0;
    #1;
    check("arst fix_out", 32'(fix_out), 32'h0);
    check("arst fix_vld", 32'(fix_out_valid), 32'h0);
    check("arst fl_out", fl_out, 32'h0);
    check("arst fl_vld", 32'(fl_out_valid), 32'h0);
    @(negedge clk);
    check("arst held", {fl_out[21:0] | fix_out, 8'(0), fl_out_valid, fix_out_valid}, 32'h0);
    fl_in_valid  = 1'b0;
    fix_in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post-rst idle", {fl_out[31:2] | 30'(fix_out), fl_out_valid, fix_out_valid}, 32'h0);
    do_fl("post-rst", 32'h3F000000, 22'h080000);
    do_fix("post-rst", 22'h100000, 32'h3F800000);
    fl_in_valid  = 1'b0;
    fix_in_valid = 1'b0;

    // Round trip fixed -> float -> fixed over boundary and random codes.
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       code = 22'h200000;
        1:       code = 22'h1FFFFF;
        2:       code = 22'h000001;
        3:       code = 22'h3FFFFF;
        4:       code = 22'h000000;
        default: code = 22'($urandom);
      endcase
      fix_in       = code;
      fix_in_valid = 1'b1;
      @(negedge clk);
      mid          = fl_out;
      fix_in_valid = 1'b0;
      fl_in        = mid;
      fl_in_valid  = 1'b1;
      @(negedge clk);
      fl_in_valid  = 1'b0;
      check($sformatf("rtrip %06h", code), 32'(fix_out), 32'(code));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fixed_float_conv.md
Name: fixed_float_conv

Overview:
Registered bidirectional converter between IEEE-754 single precision and the CORDIC datapath's 22-bit signed fixed-point format, Q2.20 (sign, 1 integer bit, 20 fraction bits; range [-2, 2)).
- The float-to-fixed path feeds the CORDIC front end.
- The fixed-to-float path packs the CORDIC result back to float.
- The two paths are independent; each has 1-cycle latency and a valid flag.

Parameters:
FRAC_BITS, 20, number of fraction bits in the fixed format.
FIX_W, 22, total fixed-point width (two's complement).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
fl_in  input  32  IEEE-754 single to convert to fixed.
fl_in_valid  input  1  qualifies fl_in.
fix_out  output  22  Q2.20 result of fl_in.
fix_out_valid  output  1  qualifies fix_out.
fix_in  input  22  Q2.20 value to convert to float.
fix_in_valid  input  1  qualifies fix_in.
fl_out  output  32  IEEE-754 single result of fix_in.
fl_out_valid  output  1  qualifies fl_out.

Behaviour:
- Reset: rst_n low asynchronously clears fix_out, fl_out, fix_out_valid and fl_out_valid to 0. Reset mid-operation discards in-flight results.
- Latency: valid input sampled at edge N produces output and valid = 1 after edge N; valid drops 1 cycle after the input valid drops.
- Output hold: outputs keep their last value while the corresponding input valid is low.
- Back-to-back: full throughput, one conversion per cycle per path; both paths may be active in the same cycle.

Float-to-fixed (fl_in -> fix_out):
- Fields: s, e (8-bit), m (23-bit); significand = {1, m}.
- Scaling: value magnitude = significand shifted by (e - 127 - 23 + FRAC_BITS).
- Rounding: truncate the magnitude toward zero, then negate (two's complement) if s = 1.
- Zero: e = 0 (zero and denormals) -> 0x000000. Magnitudes below 2^-20 also truncate to 0.
- Saturation: |value| >= 2 (e >= 128), including infinity -> 0x1FFFFF if s = 0, 0x200000 if s = 1. Exactly -2.0 -> 0x200000.
- NaN (e = 255, m != 0) -> 0x000000.

Fixed-to-float (fix_in -> fl_out):
- Sign and magnitude: s = fix_in[21]; magnitude = |fix_in|, 22-bit unsigned, where 0x200000 gives 2^21.
- Zero: fix_in = 0 -> 0x00000000 (+0).
- Normalisation: leading-one position p (0..21) gives exponent = 127 + p - FRAC_BITS. The mantissa is the bits below the leading one, left-aligned into 23 bits with zero fill.
- Exactness: the conversion is always exact; no rounding and no denormal output.

Decomposition:
- Shared package cordic_pkg holds FIX_W, FRAC_BITS, the float field widths, the exponent bias 127, and the saturation constants FIX_MAX = 0x1FFFFF and FIX_MIN = 0x200000.
- One natural sub-module is lzc22, a 22-bit leading-zero counter used by the fixed-to-float path.
- The float-to-fixed shifter stays inline.

Test Plan:
1. fl_in 0x3F800000 (1.0) with valid -> fix_out 0x100000 and valid one cycle later. fl_in 0x3F000000 (0.5) -> 0x080000.
2. fl_in 0xBF490FDB (-0.7853982) -> fix_out 0x336F03 (truncated magnitude 0x0C90FD, negated). fl_in 0x00000000 -> 0x000000.
3. fl_in 0x40200000 (2.5) -> 0x1FFFFF; 0xC0000000 (-2.0) -> 0x200000; 0x7F800000 (+inf) -> 0x1FFFFF; 0x7FC00000 (NaN) -> 0x000000.
4. fix_in 0x09B74E -> fl_out 0x3F1B74E0. fix_in 0x100000 -> 0x3F800000; 0x200000 -> 0xC0000000; 0x000001 -> 0x35800000; 0x000000 -> 0x00000000.
5. Both paths driven every cycle with random values -> one result per cycle each. Round trip fixed -> float -> fixed returns the original value for all 2^22 codes.
6. Assert rst_n low mid-stream, asynchronously between edges -> all outputs and valids read 0 immediately and stay 0 until a valid input is sampled after rst_n rises.
